// File: rtl/rgb_to_ycbcr422.sv
// ----------------------------------------------------------------------------
// rgb_to_ycbcr422
//
// Purpose:
//    Converts one RGB888 pixel per clock into BT.601 limited-range YCbCr and
//    decimates the chroma to 4:2:2 for the ADV7511 data pins. DE and the syncs
//    travel through a matching delay line, so they stay aligned with the data.
//    The total latency is a fixed 4 clocks.
//
// Optional feature macro:
//    CHROMA_AVG_EN - when defined, each pixel pair carries averaged chroma.
//                    When undefined, chroma is co-sited on the even pixel.
//                    The latency is the same in both builds.
//
// Ports:
//    clk        in   1   pixel clock
//    rst_n      in   1   asynchronous active-low reset
//    in_r/g/b   in   8   RGB888 pixel, valid when in_de=1
//    in_de      in   1   active-video flag
//    in_hsync   in   1   horizontal sync (polarity H_SYNC_POL)
//    in_vsync   in   1   vertical sync (polarity V_SYNC_POL)
//    out_ycbcr  out  16  even pixel {Cb,Y}, odd pixel {Cr,Y}, 16'h8010 in blanking
//    out_de     out  1   in_de delayed by LATENCY clocks
//    out_hsync  out  1   in_hsync delayed by LATENCY clocks
//    out_vsync  out  1   in_vsync delayed by LATENCY clocks
// ----------------------------------------------------------------------------

package video_pkg;
   // Packed 4:2:2 word: upper byte is chroma (Cb on even, Cr on odd), lower is luma.
   typedef struct packed {
      logic [7:0] c;
      logic [7:0] y;
   } ycbcr422_t;

   // Active-low syncs; the inactive level is therefore 1.
   localparam logic H_SYNC_POL = 1'b0;
   localparam logic V_SYNC_POL = 1'b0;
endpackage

module rgb_to_ycbcr422 #(
   parameter int LATENCY = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [7:0]           in_r,
   input  logic [7:0]           in_g,
   input  logic [7:0]           in_b,
   input  logic                 in_de,
   input  logic                 in_hsync,
   input  logic                 in_vsync,
   output video_pkg::ycbcr422_t out_ycbcr,
   output logic                 out_de,
   output logic                 out_hsync,
   output logic                 out_vsync
);

   import video_pkg::*;

   // The stage structure below is hard-wired to four registers.
   generate
      if (LATENCY != 4) begin : g_latency_check
         $error("rgb_to_ycbcr422: LATENCY must be 4");
      end
   endgenerate

   localparam logic signed [17:0] K_YR = 18'sd66;
   localparam logic signed [17:0] K_YG = 18'sd129;
   localparam logic signed [17:0] K_YB = 18'sd25;
   localparam logic signed [17:0] K_BR = 18'sd38;
   localparam logic signed [17:0] K_BG = 18'sd74;
   localparam logic signed [17:0] K_BB = 18'sd112;
   localparam logic signed [17:0] K_RR = 18'sd112;
   localparam logic signed [17:0] K_RG = 18'sd94;
   localparam logic signed [17:0] K_RB = 18'sd18;

   localparam logic [7:0]  BLANK_Y  = 8'd16;
   localparam logic [7:0]  BLANK_C  = 8'd128;
   localparam logic [15:0] BLANK_YC = 16'h8010;

   // Saturate a signed intermediate into an 8-bit range [lo,hi].
   function automatic logic [7:0] clamp8(input logic signed [17:0] v,
                                         input logic signed [17:0] lo,
                                         input logic signed [17:0] hi);
      logic [7:0] res;
      if (v < lo) begin
         res = lo[7:0];
      end else if (v > hi) begin
         res = hi[7:0];
      end else begin
         res = v[7:0];
      end
      return res;
   endfunction

`ifdef CHROMA_AVG_EN
   // Rounded mean of two chroma samples, using a 9-bit sum to avoid overflow.
   function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, b} + 9'd1;
      return s[8:1];
   endfunction
`endif

   // ---------------- pixel phase ----------------
   // r_phase is the phase the next DE-high pixel will take (0 = even).
   logic r_phase;

   // ---------------- S1: products ----------------
   logic signed [17:0] w_r18, w_g18, w_b18;
   logic signed [17:0] r_p_yr, r_p_yg, r_p_yb;
   logic signed [17:0] r_p_br, r_p_bg, r_p_bb;
   logic signed [17:0] r_p_rr, r_p_rg, r_p_rb;
   logic               r_s1_de, r_s1_odd;

   // ---------------- S2: sums / clamp ----------------
   logic signed [17:0] w_y_sum, w_cb_sum, w_cr_sum;
   logic signed [17:0] w_y_full, w_cb_full, w_cr_full;
   logic [7:0]         r_s2_y, r_s2_cb, r_s2_cr;
   logic               r_s2_de, r_s2_odd;

   // ---------------- S3: pair hold ----------------
   logic [7:0]         r_s3_y, r_s3_cb, r_s3_cr;
   logic               r_s3_de, r_s3_odd;

   // ---------------- S4: pack ----------------
   logic [7:0]         r_cr_hold;
   logic [7:0]         w_cr_hold_nxt;
   logic [7:0]         w_cb_sel;
   ycbcr422_t          w_out_nxt;
   ycbcr422_t          r_out;

   // ---------------- sync / DE delay line ----------------
   logic [LATENCY-1:0] r_de_dly, r_hs_dly, r_vs_dly;

   assign w_r18 = $signed({10'd0, in_r});
   assign w_g18 = $signed({10'd0, in_g});
   assign w_b18 = $signed({10'd0, in_b});

   // Phase clears during blanking so every line starts on an even pixel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase <= 1'b0;
      end else begin
         r_phase <= in_de & ~r_phase;
      end
   end

   // S1: capture the nine coefficient products together with DE and phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_p_yr   <= 18'sd0;
         r_p_yg   <= 18'sd0;
         r_p_yb   <= 18'sd0;
         r_p_br   <= 18'sd0;
         r_p_bg   <= 18'sd0;
         r_p_bb   <= 18'sd0;
         r_p_rr   <= 18'sd0;
         r_p_rg   <= 18'sd0;
         r_p_rb   <= 18'sd0;
         r_s1_de  <= 1'b0;
         r_s1_odd <= 1'b0;
      end else begin
         r_p_yr   <= w_r18 * K_YR;
         r_p_yg   <= w_g18 * K_YG;
         r_p_yb   <= w_b18 * K_YB;
         r_p_br   <= w_r18 * K_BR;
         r_p_bg   <= w_g18 * K_BG;
         r_p_bb   <= w_b18 * K_BB;
         r_p_rr   <= w_r18 * K_RR;
         r_p_rg   <= w_g18 * K_RG;
         r_p_rb   <= w_b18 * K_RB;
         r_s1_de  <= in_de;
         r_s1_odd <= in_de & r_phase;
      end
   end

   // Negative coefficients are stored as magnitudes and subtracted here.
   assign w_y_sum   = r_p_yr + r_p_yg + r_p_yb + 18'sd128;
   assign w_cb_sum  = r_p_bb - r_p_br - r_p_bg + 18'sd128;
   assign w_cr_sum  = r_p_rr - r_p_rg - r_p_rb + 18'sd128;
   assign w_y_full  = (w_y_sum  >>> 8) + 18'sd16;
   assign w_cb_full = (w_cb_sum >>> 8) + 18'sd128;
   assign w_cr_full = (w_cr_sum >>> 8) + 18'sd128;

   // S2: round, offset and clamp into limited range.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_y   <= BLANK_Y;
         r_s2_cb  <= BLANK_C;
         r_s2_cr  <= BLANK_C;
         r_s2_de  <= 1'b0;
         r_s2_odd <= 1'b0;
      end else begin
         r_s2_y   <= clamp8(w_y_full,  18'sd16, 18'sd235);
         r_s2_cb  <= clamp8(w_cb_full, 18'sd16, 18'sd240);
         r_s2_cr  <= clamp8(w_cr_full, 18'sd16, 18'sd240);
         r_s2_de  <= r_s1_de;
         r_s2_odd <= r_s1_odd;
      end
   end

   // S3: hold the pixel so an even pixel can see its odd partner sitting in S2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s3_y   <= BLANK_Y;
         r_s3_cb  <= BLANK_C;
         r_s3_cr  <= BLANK_C;
         r_s3_de  <= 1'b0;
         r_s3_odd <= 1'b0;
      end else begin
         r_s3_y   <= r_s2_y;
         r_s3_cb  <= r_s2_cb;
         r_s3_cr  <= r_s2_cr;
         r_s3_de  <= r_s2_de;
         r_s3_odd <= r_s2_odd;
      end
   end

`ifdef CHROMA_AVG_EN
   // An even pixel has a partner only if the next pixel is an active odd pixel.
   logic w_partner;
   assign w_partner = r_s2_de & r_s2_odd;
`endif

   // S4 select: the even pixel emits Cb and parks the pair's Cr for its partner.
   always_comb begin
      w_out_nxt     = BLANK_YC;
      w_cr_hold_nxt = r_cr_hold;
      w_cb_sel      = r_s3_cb;
      if (!r_s3_de) begin
         w_out_nxt     = BLANK_YC;
         w_cr_hold_nxt = r_cr_hold;
      end else if (!r_s3_odd) begin
`ifdef CHROMA_AVG_EN
         if (w_partner) begin
            w_cb_sel      = avg8(r_s3_cb, r_s2_cb);
            w_cr_hold_nxt = avg8(r_s3_cr, r_s2_cr);
         end else begin
            // Dangling even pixel: own Cb, no Cr is ever emitted.
            w_cb_sel      = r_s3_cb;
            w_cr_hold_nxt = r_s3_cr;
         end
`else
         w_cb_sel      = r_s3_cb;
         w_cr_hold_nxt = r_s3_cr;
`endif
         w_out_nxt = {w_cb_sel, r_s3_y};
      end else begin
         w_out_nxt     = {r_cr_hold, r_s3_y};
         w_cr_hold_nxt = r_cr_hold;
      end
   end

   // S4: output register and the pair's held Cr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out     <= BLANK_YC;
         r_cr_hold <= BLANK_C;
      end else begin
         r_out     <= w_out_nxt;
         r_cr_hold <= w_cr_hold_nxt;
      end
   end

   // DE and sync delay line; the signals are only delayed, never modified.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_de_dly <= {LATENCY{1'b0}};
         r_hs_dly <= {LATENCY{~H_SYNC_POL}};
         r_vs_dly <= {LATENCY{~V_SYNC_POL}};
      end else begin
         r_de_dly <= {r_de_dly[LATENCY-2:0], in_de};
         r_hs_dly <= {r_hs_dly[LATENCY-2:0], in_hsync};
         r_vs_dly <= {r_vs_dly[LATENCY-2:0], in_vsync};
      end
   end

   assign out_ycbcr = r_out;
   assign out_de    = r_de_dly[LATENCY-1];
   assign out_hsync = r_hs_dly[LATENCY-1];
   assign out_vsync = r_vs_dly[LATENCY-1];

endmodule
